// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a sync FIFO in fixed bursts onto a valid/ready stream
// Define FIFO_BURST_READER_STATS_EN to add the stat_bursts/stat_partial counters.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_partial
`endif
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state, state_next;
  logic [BW-1:0]         blen, blen_next, issued;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf_data1;
  logic                  buf_last1;
  logic                  start, start_full, start_flush;
  logic                  push, pop, pop_last, tag;

  assign start_full  = fifo_count >= CNT_WIDTH'(BURST_LEN);
  assign start_flush = flush && (fifo_count != '0);
  assign push        = fifo_ren;
  assign pop         = m_valid && m_ready;
  assign pop_last    = pop && m_last;
  assign tag         = (issued == blen - BW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    blen_next  = blen;
    case (state)
      IDLE: begin
        // Threshold wins over flush, so a simultaneous flush still yields a full burst.
        if (start_full) begin
          start      = 1'b1;
          blen_next  = BW'(BURST_LEN);
          state_next = BURST;
        end else if (start_flush) begin
          start      = 1'b1;
          blen_next  = BW'(fifo_count);
          state_next = BURST;
        end
      end
      BURST: begin
        if (pop_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // fifo_ren looks only at registered state, never at m_ready.
  always_comb begin
    busy     = (state == BURST);
    m_valid  = (buf_cnt != 2'd0);
    fifo_ren = (state == BURST) && (issued < blen) && (buf_cnt != 2'd2) && !fifo_empty;
  end

  // Entry 0 is the stream head (m_data/m_last); entry 1 is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      blen      <= '0;
      issued    <= '0;
      buf_cnt   <= 2'd0;
      m_data    <= '0;
      m_last    <= 1'b0;
      buf_data1 <= '0;
      buf_last1 <= 1'b0;
    end else begin
      if (start) begin
        blen   <= blen_next;
        issued <= '0;
      end else if (push) begin
        issued <= issued + BW'(1);
      end
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            m_data <= fifo_rdata;
            m_last <= tag;
          end else begin
            buf_data1 <= fifo_rdata;
            buf_last1 <= tag;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          m_data  <= buf_data1;
          m_last  <= (buf_cnt == 2'd2) ? buf_last1 : 1'b0;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            m_data <= fifo_rdata;
            m_last <= tag;
          end else begin
            m_data    <= buf_data1;
            m_last    <= buf_last1;
            buf_data1 <= fifo_rdata;
            buf_last1 <= tag;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts  <= 16'd0;
      stat_partial <= 16'd0;
    end else begin
      if (pop_last) stat_bursts <= stat_bursts + 16'd1;
      if (start && (blen_next < BW'(BURST_LEN))) stat_partial <= stat_partial + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
// Drives a small behavioural FIFO model and logs every accepted stream beat.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_ren;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic [5:0] fifo_count;
  logic       flush = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] stat_bursts;
  logic [15:0] stat_partial;
`endif

  fifo_burst_reader #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (32),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .stat_bursts  (stat_bursts),
    .stat_partial (stat_partial)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_count = 6'(wr_ptr - rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_ren && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  logic [7:0] acc_data [0:255];
  logic       acc_last [0:255];
  int         acc_cyc  [0:255];
  int acc_n   = 0;
  int cyc     = 0;
  int occ     = 0;
  int viol    = 0;
  int ren_cnt = 0;

  // Beats are sampled mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      occ <= 0;
    end else begin
      if (fifo_ren && occ == 2) viol <= viol + 1;
      if (fifo_ren) ren_cnt <= ren_cnt + 1;
      if (m_valid && m_ready) begin
        acc_data[acc_n] <= m_data;
        acc_last[acc_n] <= m_last;
        acc_cyc[acc_n]  <= cyc;
        acc_n           <= acc_n + 1;
      end
      occ <= occ + (fifo_ren ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic chk_beats(input string tag, input int b, input int n,
                           input logic [7:0] first, input int last_mask);
    chk({tag, "_count"}, 32'(acc_n - b), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(acc_data[b + i]), 32'(first) + 32'(i));
      chk({tag, "_last"}, 32'(acc_last[b + i]), 32'((last_mask >> i) & 1));
    end
  endtask

  int b;
  int r;
  logic [7:0] held;

  initial begin
    tick(2);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_ren", 32'(fifo_ren), 32'd0);
    rst = 1'b0;

    // Full bursts: two back-to-back bursts of four
    m_ready = 1'b1;
    b = acc_n;
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    tick(1);
    chk("full_busy_n1", 32'(busy), 32'd1);
    chk("full_ren_n1", 32'(fifo_ren), 32'd1);
    chk("full_valid_n1", 32'(m_valid), 32'd0);
    tick(1);
    chk("full_valid_n2", 32'(m_valid), 32'd1);
    chk("full_data_n2", 32'(m_data), 32'h10);
    tick(12);
    chk_beats("full", b, 8, 8'h10, 32'h88);
    for (int i = 0; i < 3; i++)
      chk("full_consecutive", 32'(acc_cyc[b + i + 1] - acc_cyc[b + i]), 32'd1);
    chk("full_count_end", 32'(fifo_count), 32'd0);
    chk("full_busy_end", 32'(busy), 32'd0);

    // Flush with an empty FIFO is ignored
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_empty_busy", 32'(busy), 32'd0);
    tick(1);
    chk("flush_empty_valid", 32'(m_valid), 32'd0);

    // Below threshold: nothing until flush, then a 3-word partial burst
    b = acc_n;
    r = ren_cnt;
    push_word(8'h20);
    push_word(8'h21);
    push_word(8'h22);
    tick(6);
    chk("below_no_ren", 32'(ren_cnt - r), 32'd0);
    chk("below_valid", 32'(m_valid), 32'd0);
    chk("below_busy", 32'(busy), 32'd0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("partial_busy", 32'(busy), 32'd1);
    tick(6);
    chk_beats("partial", b, 3, 8'h20, 32'h4);
    chk("partial_count_end", 32'(fifo_count), 32'd0);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("partial_stat", 32'(stat_partial), 32'd1);
`endif

    // Backpressure: skid buffer fills to two and holds
    m_ready = 1'b0;
    b = acc_n;
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
    tick(6);
    chk("bp_ren", 32'(fifo_ren), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'h30);
    chk("bp_count", 32'(fifo_count), 32'd2);
    held = m_data;
    tick(2);
    chk("bp_data_held", 32'(m_data), 32'(held));
    chk("bp_no_beats", 32'(acc_n - b), 32'd0);
    m_ready = 1'b1;
    tick(8);
    chk_beats("bp", b, 4, 8'h30, 32'h8);

    // Alternating ready over eight words
    b = acc_n;
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      tick(1);
    end
    m_ready = 1'b1;
    chk_beats("alt", b, 8, 8'h40, 32'h88);
    chk("alt_ren_when_full", 32'(viol), 32'd0);

    // Reset after the second beat of a burst
    b = acc_n;
    for (int i = 0; i < 6; i++) push_word(8'h50 + 8'(i));
    tick(4);
    chk("rstmid_beats", 32'(acc_n - b), 32'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_last", 32'(m_last), 32'd0);
    chk("rstmid_count", 32'(fifo_count), 32'd2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(5);
    chk("rstmid_total", 32'(acc_n - b), 32'd4);
    chk("rstmid_d0", 32'(acc_data[b]), 32'h50);
    chk("rstmid_l0", 32'(acc_last[b]), 32'd0);
    chk("rstmid_d1", 32'(acc_data[b + 1]), 32'h51);
    chk("rstmid_l1", 32'(acc_last[b + 1]), 32'd0);
    chk("rstmid_d2", 32'(acc_data[b + 2]), 32'h54);
    chk("rstmid_l2", 32'(acc_last[b + 2]), 32'd0);
    chk("rstmid_d3", 32'(acc_data[b + 3]), 32'h55);
    chk("rstmid_l3", 32'(acc_last[b + 3]), 32'd1);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("rstmid_stat_bursts", 32'(stat_bursts), 32'd1);
    chk("rstmid_stat_partial", 32'(stat_partial), 32'd1);
`endif

    // Flush together with threshold: full-length burst, not partial
    b = acc_n;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h60 + 8'(i));
    tick(1);
    flush = 1'b0;
    chk("both_busy", 32'(busy), 32'd1);
    tick(7);
    chk_beats("both", b, 4, 8'h60, 32'h8);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("both_stat_bursts", 32'(stat_bursts), 32'd2);
    chk("both_stat_partial", 32'(stat_partial), 32'd1);
`endif
    chk("final_ren_when_full", 32'(viol), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO's ren and takes rdata, empty and count from it.
- Drains the FIFO in fixed-length bursts and presents the words on a valid/ready stream with an end-of-burst marker (m_last).
- Sits between a generic_sync_fifo instance and a downstream packet consumer. Contains a 2-entry output skid buffer so that no combinational path exists from m_ready to fifo_ren.

Parameters:
- DATA_WIDTH, 8: width of the FIFO word and of m_data.
- FIFO_DEPTH, 32: depth of the attached FIFO.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1: width of fifo_count.
- BURST_LEN, 4: words per normal burst. Legal range is 1..FIFO_DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_ren  output  1  read enable to the FIFO.
- fifo_rdata  input  DATA_WIDTH  FIFO head word, combinational (valid while !fifo_empty).
- fifo_empty  input  1  FIFO empty flag.
- fifo_count  input  CNT_WIDTH  FIFO occupancy.
- flush  input  1  single-cycle request to send a partial burst.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream accept.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  marks the final word of the current burst.
- busy  output  1  high while state is BURST.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; skid buffer empty; m_valid=0, m_last=0, m_data=0, busy=0, fifo_ren=0; all counters 0.
- IDLE -> BURST when fifo_count >= BURST_LEN. The burst length is latched as blen=BURST_LEN.
- Otherwise IDLE -> BURST when flush=1 and fifo_count>0. The burst length is latched as blen=min(fifo_count, BURST_LEN).
- flush is ignored while in BURST, and ignored in IDLE when fifo_count==0.
- In BURST:
  - fifo_ren = (issued < blen) && (buf_cnt < 2) && !fifo_empty.
  - On each fifo_ren cycle, fifo_rdata is written into the skid buffer at that clock edge and issued increments.
  - Each entry carries a last tag, set when issued == blen-1 at capture.
- Output side:
  - m_valid = (buf_cnt > 0). m_data and m_last come from the buffer head and are register outputs.
  - A pop occurs when m_valid && m_ready.
  - Push and pop in the same cycle leave buf_cnt unchanged.
  - m_data and m_last are held stable while m_valid && !m_ready.
- BURST -> IDLE on the cycle the entry tagged last is popped. A new burst may start on the following cycle, evaluated in IDLE.
- Latency:
  - fifo_count meets the condition in cycle N, BURST is entered at N+1, fifo_ren is asserted at N+1, and m_valid goes high at N+2.
  - With m_ready held high, throughput is one word per cycle and the burst completes at N+1+blen.
- fifo_empty asserted mid-burst (another reader or a corrupted count): fifo_ren is held low and the burst stalls without error until data arrives.
- Widths:
  - issued and the beat counters are $clog2(BURST_LEN+1) bits.
  - buf_cnt is 2 bits.
  - blen is compared on the full width of fifo_count.
- rst asserted mid-burst: the next edge returns the block to the reset values. Buffered words are discarded and no m_last is emitted.
- fifo_ren never depends combinationally on m_ready.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- When defined, two extra output ports are added:
  - stat_bursts (16 bits): increments on every popped last-tagged word.
  - stat_partial (16 bits): increments on every burst started by flush with blen < BURST_LEN.
- Both counters wrap at 2^16 and are cleared by rst.
- When not defined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Full burst: BURST_LEN=4, FIFO preloaded with 0x10..0x17, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles with m_last on 0x13, then 0x14..0x17 as a second burst with m_last on 0x17; fifo_count ends at 0.
- Below threshold: 3 words written, no flush -> fifo_ren stays 0 and m_valid stays 0 indefinitely. Pulse flush -> 3 words out with m_last on the third; stat_partial=1 when the macro is defined.
- Backpressure: m_ready=0 for 5 cycles during a burst -> buf_cnt saturates at 2, fifo_ren=0, m_data held stable. Release m_ready -> no word lost or duplicated, original order preserved.
- Alternating m_ready (1,0,1,0...) over 8 words -> exactly 8 accepted beats, 2 m_last pulses, and fifo_ren never high in a cycle where buf_cnt==2.
- Reset mid-burst: rst high for 1 cycle after the 2nd beat -> next cycle m_valid=0, busy=0, state IDLE. The next burst starts cleanly from fifo_count.
- Simultaneous flush and threshold: fifo_count=4 and flush=1 in the same IDLE cycle -> blen=4 and stat_partial is not incremented.
